// File: rtl/vga_pkg.sv
// Default VGA 640x480@60 timing, colour and video-beat types, and the palette lookup
// shared by the Game Boy VGA output stage.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int PIX_CODE_W   = 2;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // One pixel-clock beat of the output stream: syncs, enable, frame marker, colour.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        rgb_t rgb;
    } vid_t;

    function automatic rgb_t pal_entry(input logic [4*12-1:0]       pal,
                                       input logic [PIX_CODE_W-1:0] code);
        return rgb_t'(pal[int'(code)*12 +: 12]);
    endfunction

endpackage

// File: rtl/gb_frame_ram.sv
// Simple dual-port frame store: one source line per word, synchronous read-first
// with one cycle of read latency, written so that it maps onto block RAM.
module gb_frame_ram #(
    parameter int DEPTH = 144,
    parameter int WIDTH = 320,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset: contents survive resetN, and a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gb_vga_scaler.sv
// Game Boy VGA output stage: parametrised sync timing, centred integer-scaled window
// with palette and border colour, all outputs delayed two clocks from the counters.
module gb_vga_scaler
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int SRC_W    = 160,
    parameter int SRC_H    = 144,
    parameter int PIX_BITS = PIX_CODE_W,
    parameter int SCALE    = 3,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                      pixelClk,
    input  logic                      resetN,
    input  logic [SRC_W*PIX_BITS-1:0] lineData,
    input  logic [7:0]                lineY,
    input  logic                      lineValid,
    input  logic [4*12-1:0]           palette,
    input  logic [11:0]               borderColor,
    output logic                      HSync,
    output logic                      VSync,
    output logic [3:0]                R,
    output logic [3:0]                G,
    output logic [3:0]                B,
    output logic                      de,
    output logic                      frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WIN_W   = SRC_W * SCALE;
    localparam int WIN_H   = SRC_H * SCALE;
    localparam int X0      = (H_ACTIVE - WIN_W) / 2;
    localparam int Y0      = (V_ACTIVE - WIN_H) / 2;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int AW      = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int LW      = SRC_W * PIX_BITS;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_RD     = HW'(H_TOTAL - 3);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_BEG    = HW'(X0);
    localparam logic [HW-1:0] X_END    = HW'(X0 + WIN_W);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_BEG    = VW'(Y0);
    localparam logic [VW-1:0] Y_END    = VW'(Y0 + WIN_H);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

    localparam vid_t VID_IDLE = '{hs: !SYNC_POL, vs: !SYNC_POL, de: 1'b0, fs: 1'b0, rgb: '0};

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d, v_next;
    logic [SW-1:0] h_sub_q, h_sub_d;
    logic [SW-1:0] v_sub_q, v_sub_d;
    logic [AW-1:0] src_y_q, src_y_d;
    logic [LW-1:0] shifter_q, shifter_d;
    logic [LW-1:0] rd_data;
    vid_t          s1_q, s1_d;
    vid_t          out_q;

    logic line_end, frame_end, active, in_win_x, in_win, next_in_win;
    logic rd_en, load, shift, wr_en;

    function automatic logic row_in_win(input logic [VW-1:0] v);
        return (v >= Y_BEG) && (v < Y_END);
    endfunction

    assign line_end    = (h_q == H_LAST);
    assign frame_end   = (v_q == V_LAST);
    assign v_next      = frame_end ? '0 : v_q + 1'b1;
    assign active      = (h_q < H_ACT) && (v_q < V_ACT);
    assign in_win_x    = (h_q >= X_BEG) && (h_q < X_END);
    assign in_win      = in_win_x && row_in_win(v_q);
    assign next_in_win = row_in_win(v_next);

    // Fetch the next line's row two clocks before the wrap; it lands in the shifter on the wrap.
    assign rd_en = (h_q == H_RD) && next_in_win;
    assign load  = line_end && next_in_win;

    // lineValid is a single-cycle strobe with no ready: every strobed row below SRC_H is
    // stored the same clock, anything else is dropped.
    assign wr_en = lineValid && (32'(lineY) < SRC_H);

    gb_frame_ram #(
        .DEPTH(SRC_H),
        .WIDTH(LW),
        .AW   (AW)
    ) u_frame_ram (
        .clk  (pixelClk),
        .we   (wr_en),
        .waddr(lineY[AW-1:0]),
        .wdata(lineData),
        .re   (rd_en),
        .raddr(src_y_q),
        .rdata(rd_data)
    );

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (line_end) begin
            h_d = '0;
            v_d = v_next;
        end
    end

    // src_y/v_sub describe the line after the current one, ready for the early fetch.
    always_comb begin
        v_sub_d = v_sub_q;
        src_y_d = src_y_q;
        if (line_end) begin
            if (!next_in_win) begin
                v_sub_d = '0;
                src_y_d = '0;
            end else if (v_sub_q == SUB_LAST) begin
                v_sub_d = '0;
                src_y_d = src_y_q + 1'b1;
            end else begin
                v_sub_d = v_sub_q + 1'b1;
            end
        end
    end

    always_comb begin
        h_sub_d = '0;
        shift   = 1'b0;
        if (in_win_x) begin
            h_sub_d = (h_sub_q == SUB_LAST) ? '0 : h_sub_q + 1'b1;
            shift   = in_win && (h_sub_q == SUB_LAST);
        end
        shifter_d = shifter_q;
        if (load) begin
            shifter_d = rd_data;
        end else if (shift) begin
            shifter_d = shifter_q >> PIX_BITS;
        end
    end

    always_comb begin
        s1_d    = VID_IDLE;
        s1_d.hs = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_POL : !SYNC_POL;
        s1_d.vs = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_POL : !SYNC_POL;
        s1_d.de = active;
        s1_d.fs = (h_q == '0) && (v_q == '0);
        if (active) begin
            s1_d.rgb = in_win ? pal_entry(palette, shifter_q[PIX_BITS-1:0]) : rgb_t'(borderColor);
        end
    end

    always_ff @(posedge pixelClk or negedge resetN) begin
        if (!resetN) begin
            h_q       <= '0;
            v_q       <= '0;
            h_sub_q   <= '0;
            v_sub_q   <= '0;
            src_y_q   <= '0;
            shifter_q <= '0;
            s1_q      <= VID_IDLE;
            out_q     <= VID_IDLE;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            h_sub_q   <= h_sub_d;
            v_sub_q   <= v_sub_d;
            src_y_q   <= src_y_d;
            shifter_q <= shifter_d;
            s1_q      <= s1_d;
            out_q     <= s1_q;
        end
    end

    assign HSync      = out_q.hs;
    assign VSync      = out_q.vs;
    assign de         = out_q.de;
    assign frameStart = out_q.fs;
    assign R          = out_q.rgb.r;
    assign G          = out_q.rgb.g;
    assign B          = out_q.rgb.b;

endmodule

// File: doc/gb_vga_scaler.md
# gb_vga_scaler

Parametrised VGA output stage for the Game Boy core. It holds a full source frame (default 160x144, 2-bit pixels) written line by line by the PPU, and generates VGA timing with fully parametrised porches and sync. The frame is shown centred at an integer scale with a programmable 4-entry palette and border colour. It replaces the fixed 640x480, 1-bit, top-left, unscaled display path and sits between the PPU and the board's 4:4:4 VGA DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths in pixel clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths in lines
- SRC_W / SRC_H, 160 / 144, source frame size
- PIX_BITS, 2, bits per source pixel
- SCALE, 3, integer upscale factor; SRC_W*SCALE <= H_ACTIVE and SRC_H*SCALE <= V_ACTIVE
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- pixelClk  in  1  pixel clock; the only clock
- resetN  in  1  asynchronous, active-low reset
- lineData  in  SRC_W*PIX_BITS  one source line; pixel x = lineData[x*PIX_BITS +: PIX_BITS]
- lineY  in  8  source row index of lineData
- lineValid  in  1  single-cycle write strobe for lineData/lineY
- palette  in  4*12  entry p = palette[p*12 +: 12] = {R,G,B}
- borderColor  in  12  {R,G,B} for active area outside the window
- HSync, VSync  out  1  sync outputs
- R, G, B  out  4 each  colour; 0 in blanking
- de  out  1  display enable, aligned with RGB
- frameStart  out  1  one-cycle pulse, aligned with first active pixel of each frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hCount runs 0..H_TOTAL-1 and wraps. vCount advances in the same cycle hCount wraps and runs 0..V_TOTAL-1. Both are synchronous to pixelClk; no derived clocks.
- HSync is active for hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; VSync is active for vCount in the vertical equivalent.
- Window origin: X0 = (H_ACTIVE-SRC_W*SCALE)/2, Y0 = (V_ACTIVE-SRC_H*SCALE)/2, truncating.
- Source coordinates come from sub-counters, not dividers:
  - hSub counts 0..SCALE-1 and increments srcX on wrap.
  - vSub/srcY do the same per line.
- Write port: on lineValid with lineY < SRC_H, store lineData at row lineY. Writes with lineY >= SRC_H are ignored. No backpressure; any row may be written at any time.
- Read port:
  - At hCount == H_TOTAL-3 on lines feeding the window, read the row for the next display line.
  - At hCount == H_TOTAL-1, load it into a pixel shifter.
  - The shifter advances one pixel every SCALE clocks inside the window.
- Colour select:
  - inside the window: palette[pixel];
  - active area outside the window: borderColor;
  - blanking: 0.
- Same-row write and read in the same cycle returns old data (read-first).
- RAM contents are not cleared by reset.

## Timing
- Reset values: hCount = vCount = 0; HSync = VSync = ~SYNC_POL (inactive); R = G = B = 0; de = 0; frameStart = 0; shifter = 0.
- Latency: counter position (h,v) appears on R/G/B/de two clocks later. HSync, VSync and frameStart are delayed by the same two clocks, so all outputs stay mutually aligned.
- Write-to-display: a row written before hCount == H_TOTAL-3 of the line preceding its first display line is shown on that line.
- Reset deasserted mid-frame restarts timing at (0,0) on the next clock edge. The first frame is fully timed but shows stale RAM.

## Structure
- Package vga_pkg holds the default VGA 640x480@60 timing constants, the typedef for the 12-bit RGB colour, and the pixel-code width.
- Sub-module gb_frame_ram: simple dual-port, SRC_H words x SRC_W*PIX_BITS bits, synchronous read-first, one-cycle read latency. It should infer block RAM.
- Timing counters, scale counters, shifter and output pipeline live in gb_vga_scaler.

## Test plan
- **Reset:** hold resetN low, toggle pixelClk → HSync = VSync = 1, RGB = 0, de = 0, frameStart = 0. Release → hCount starts at 0.
- **Sync timing (defaults):** HSync low for 96 clocks starting at hCount 656 (seen at output clock 658), period 800. VSync low for lines 490–491, period 525 lines.
- **Pixel scaling:**
  - Stimulus: write row 0 with pixel0 = 3, pixel1 = 0; palette[3] = 12'hF00, palette[0] = 12'h000.
  - Lines 24–26, hCount 80–82 → RGB = F,0,0 two clocks later.
  - hCount 83–85 → 0,0,0.
- **Border and blanking:** borderColor = 12'h00F. Line 10, hCount 10 → RGB = 0,0,F with de = 1. hCount 700 → RGB = 0, de = 0.
- **Write filtering and collision:**
  - Write lineY = 150 → RAM unchanged.
  - Write row 5 in the same cycle as its read → current display shows old row 5; the next frame shows new data.
- **frameStart:** asserts exactly once per 420000 clocks, coincident with de rising at line 0, pixel 0.
